spi_slave: RTL



---
 rtl/spi_slave.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI target peripheral: oversamples the SPI pins on clk, moves 8-bit MSB-first frames
// in any CPOL/CPHA mode and exposes them through a four-register bus interface.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    input  logic        spi_clk,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        irq
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
    logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic start, stop, sample, shift;

    logic [3:0] ctrl;
    logic [7:0] txdata, rxdata, tx_shift, rx_shift;
    logic [2:0] bit_cnt;
    logic       rx_valid, tx_empty, overrun;
    logic       mode_cpol, mode_cpha;
    logic       enable, busy;
    logic       wr_ctrl, wr_tx, wr_status;
    logic       unused_bits;

    assign enable    = ctrl[0];
    assign busy      = (state == ACTIVE);
    assign wr_ctrl   = we_i && (addr_i[3:0] == 4'h0);
    assign wr_tx     = we_i && (addr_i[3:0] == 4'h4);
    assign wr_status = we_i && (addr_i[3:0] == 4'hC);
    assign unused_bits = ^{addr_i[31:4], data_i[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe <= '0;
            ss_pipe   <= '0;
            mosi_pipe <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi_clk};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], spi_ss};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign ss_s      = ss_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    // Edge roles come from the mode latched at frame start, not the live CTRL bits.
    assign lead_edge   = mode_cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_cpol ? sclk_rise : sclk_fall;
    assign sample_edge = mode_cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode_cpha ? lead_edge : trail_edge;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall && enable) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise || !enable) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    sample = sample_edge;
                    shift  = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            txdata    <= '0;
            rxdata    <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_valid  <= 1'b0;
            tx_empty  <= 1'b1;
            overrun   <= 1'b0;
            mode_cpol <= 1'b0;
            mode_cpha <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl   <= data_i[3:0];
            if (wr_tx)   txdata <= data_i[7:0];
            if (wr_status) begin
                if (data_i[1]) rx_valid <= 1'b0;
                if (data_i[3]) overrun  <= 1'b0;
            end

            // CPHA=0 puts bit 7 out at select, so the register is pre-shifted by one.
            if (start) begin
                mode_cpol <= ctrl[1];
                mode_cpha <= ctrl[2];
                bit_cnt   <= '0;
                tx_empty  <= 1'b1;
                if (ctrl[2]) begin
                    tx_shift <= txdata;
                end else begin
                    tx_shift <= {txdata[6:0], 1'b0};
                    spi_miso <= txdata[7];
                end
            end

            if (stop) begin
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end

            if (shift) begin
                spi_miso <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            if (sample) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rxdata   <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                    if (rx_valid) overrun <= 1'b1;
                    if (!ss_s) begin
                        tx_shift <= txdata;
                        tx_empty <= 1'b1;
                    end
                end
            end

            if (wr_tx) tx_empty <= 1'b0;
        end
    end

    always_comb begin
        data_o = '0;
        if (!rst) begin
            case (addr_i[3:0])
                4'h0:    data_o[3:0] = ctrl;
                4'h4:    data_o[7:0] = txdata;
                4'h8:    data_o[7:0] = rxdata;
                4'hC:    data_o[3:0] = {overrun, tx_empty, rx_valid, busy};
                default: data_o = '0;
            endcase
        end
    end

    assign spi_miso_oe = ~ss_s & enable & busy;
    assign irq         = rx_valid & ctrl[3];

endmodule
